// File: rtl/alu_operand_stage_pkg.sv
// Shared types for the ALU operand stage.
//   alu_op_t      : ALU control encoding consumed by the alu
//   stage_entry_t : one buffered op {a, b, ctrl, rd} at default widths
package alu_operand_stage_pkg;

  localparam int unsigned AluWidth    = 32;
  localparam int unsigned AluRegAddrW = 5;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluOr  = 2'd2,
    AluAnd = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic [AluWidth-1:0]    a;
    logic [AluWidth-1:0]    b;
    alu_op_t                ctrl;
    logic [AluRegAddrW-1:0] rd;
  } stage_entry_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side bundle of the operand stage.
//   in_*    : op from decode with in_valid/in_ready handshake
//   exmem_* : EX/MEM write-back forwarding candidate
//   memwb_* : MEM/WB write-back forwarding candidate
//   out_*   : ALU operands/control with out_valid/out_ready handshake
// master = environment (decode, bypass network, EX); slave = the stage.
interface alu_operand_stage_if
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned Width    = AluWidth,
  parameter int unsigned RegAddrW = AluRegAddrW
) ();

  logic                in_valid;
  logic                in_ready;
  alu_op_t             in_ctrl;
  logic [RegAddrW-1:0] in_rs;
  logic [RegAddrW-1:0] in_rt;
  logic [Width-1:0]    in_rf_a;
  logic [Width-1:0]    in_rf_b;
  logic [Width-1:0]    in_imm;
  logic                in_use_imm;
  logic [RegAddrW-1:0] in_rd;

  logic                exmem_we;
  logic [RegAddrW-1:0] exmem_rd;
  logic [Width-1:0]    exmem_data;
  logic                memwb_we;
  logic [RegAddrW-1:0] memwb_rd;
  logic [Width-1:0]    memwb_data;

  logic                out_valid;
  logic                out_ready;
  logic [Width-1:0]    out_a;
  logic [Width-1:0]    out_b;
  alu_op_t             out_ctrl;
  logic [RegAddrW-1:0] out_rd;

  modport master (
    output in_valid, in_ctrl, in_rs, in_rt, in_rf_a, in_rf_b, in_imm, in_use_imm, in_rd,
    output exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
    output out_ready,
    input  in_ready, out_valid, out_a, out_b, out_ctrl, out_rd
  );

  modport slave (
    input  in_valid, in_ctrl, in_rs, in_rt, in_rf_a, in_rf_b, in_imm, in_use_imm, in_rd,
    input  exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
    input  out_ready,
    output in_ready, out_valid, out_a, out_b, out_ctrl, out_rd
  );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Priority forwarding select for one source operand.
//   src_i              : source register specifier
//   rf_data_i          : register-file read value for src_i
//   exmem_*/memwb_*    : write-back candidates (we, rd, data)
//   data_o             : EX/MEM hit, else MEM/WB hit, else regfile
// Register 0 never hits, so it always reads the regfile value.
module alu_operand_stage_fwd_mux #(
  parameter int unsigned Width    = 32,
  parameter int unsigned RegAddrW = 5
) (
  input  logic [RegAddrW-1:0] src_i,
  input  logic [Width-1:0]    rf_data_i,
  input  logic                exmem_we_i,
  input  logic [RegAddrW-1:0] exmem_rd_i,
  input  logic [Width-1:0]    exmem_data_i,
  input  logic                memwb_we_i,
  input  logic [RegAddrW-1:0] memwb_rd_i,
  input  logic [Width-1:0]    memwb_data_i,
  output logic [Width-1:0]    data_o
);

  logic src_nonzero;
  logic exmem_hit;
  logic memwb_hit;

  always_comb begin
    src_nonzero = (src_i != '0);
    exmem_hit   = exmem_we_i && (exmem_rd_i == src_i) && src_nonzero;
    memwb_hit   = memwb_we_i && (memwb_rd_i == src_i) && src_nonzero;
    if (exmem_hit) begin
      data_o = exmem_data_i;
    end else if (memwb_hit) begin
      data_o = memwb_data_i;
    end else begin
      data_o = rf_data_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID->EX operand stage feeding the ALU.
//   clk, rst : clock and synchronous active-high reset
//   flush    : drop every held op on redirect
//   bus      : decode/forwarding/ALU bundle (slave view)
// Operands are forwarded once at capture and then frozen. A main entry drives
// the outputs; a skid entry absorbs the op accepted during the cycle in which
// the downstream first stalls, so in_ready can come straight from a flop.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned Width    = AluWidth,
  parameter int unsigned RegAddrW = AluRegAddrW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  alu_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic [Width-1:0]    a;
    logic [Width-1:0]    b;
    alu_op_t             ctrl;
    logic [RegAddrW-1:0] rd;
  } entry_t;

  localparam entry_t ResetEntry = '{a: '0, b: '0, ctrl: AluAdd, rd: '0};

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic [Width-1:0] fwd_a;
  logic [Width-1:0] fwd_b;
  entry_t           cap_entry;
  logic             in_ready;
  logic             cap;
  logic             drain;

  alu_operand_stage_fwd_mux #(.Width(Width), .RegAddrW(RegAddrW)) u_fwd_a (
    .src_i       (bus.in_rs),
    .rf_data_i   (bus.in_rf_a),
    .exmem_we_i  (bus.exmem_we),
    .exmem_rd_i  (bus.exmem_rd),
    .exmem_data_i(bus.exmem_data),
    .memwb_we_i  (bus.memwb_we),
    .memwb_rd_i  (bus.memwb_rd),
    .memwb_data_i(bus.memwb_data),
    .data_o      (fwd_a)
  );

  alu_operand_stage_fwd_mux #(.Width(Width), .RegAddrW(RegAddrW)) u_fwd_b (
    .src_i       (bus.in_rt),
    .rf_data_i   (bus.in_rf_b),
    .exmem_we_i  (bus.exmem_we),
    .exmem_rd_i  (bus.exmem_rd),
    .exmem_data_i(bus.exmem_data),
    .memwb_we_i  (bus.memwb_we),
    .memwb_rd_i  (bus.memwb_rd),
    .memwb_data_i(bus.memwb_data),
    .data_o      (fwd_b)
  );

  always_comb begin
    cap_entry.a    = fwd_a;
    cap_entry.b    = bus.in_use_imm ? bus.in_imm : fwd_b;
    cap_entry.ctrl = bus.in_ctrl;
    cap_entry.rd   = bus.in_rd;
  end

  assign in_ready = ~skid_valid_q;
  assign cap      = bus.in_valid & in_ready;
  assign drain    = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Drain still completes downstream; everything else, including a capture, is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      // in_ready is low here, so no capture can collide with the skid promotion.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      main_valid_d = cap;
      if (cap) begin
        main_d = cap_entry;
      end
    end else if (main_valid_q) begin
      if (cap) begin
        skid_d       = cap_entry;
        skid_valid_d = 1'b1;
      end
    end else if (cap) begin
      main_d       = cap_entry;
      main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= ResetEntry;
      skid_q       <= ResetEntry;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_a     = main_q.a;
  assign bus.out_b     = main_q.b;
  assign bus.out_ctrl  = main_q.ctrl;
  assign bus.out_rd    = main_q.rd;

endmodule
